// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and op decode helpers for the multiply/divide unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_e;
  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction
  function automatic logic op_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: conditional two's-complement negate, used for magnitudes and sign fix-up
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide with start/done handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sres_q, sres_d, srem_q, srem_d, dz_q, dz_d, done_q, done_d, div_zero_q, div_zero_d;
  logic               sgn_in, ge;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, shifted;
  assign sgn_in = op_signed(op);
  muldiv_abs #(.WIDTH(WIDTH))   u_abs_a (.x(a), .neg(sgn_in & a[WIDTH-1]), .y(a_mag));
  muldiv_abs #(.WIDTH(WIDTH))   u_abs_b (.x(b), .neg(sgn_in & b[WIDTH-1]), .y(b_mag));
  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_p (.x(acc_q), .neg(sres_q), .y(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH))   u_fix_q (.x(acc_q[WIDTH-1:0]), .neg(sres_q), .y(quo_fix));
  muldiv_abs #(.WIDTH(WIDTH))   u_fix_r (.x(rem_q), .neg(srem_q), .y(rem_fix));
  // Multiply keeps the multiplier in acc[W-1:0]; divide keeps the dividend/quotient there.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mb_q};
  assign busy     = state_q != ST_IDLE;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    sres_d     = sres_q;
    srem_d     = srem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        op_d       = op;
        ma_d       = a_mag;
        mb_d       = b_mag;
        sres_d     = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
        srem_d     = sgn_in & a[WIDTH-1];
        div_zero_d = 1'b0;
        dz_d       = op_div(op) && (b == '0);
        rem_d      = '0;
        cnt_d      = '0;
        acc_d      = {{WIDTH{1'b0}}, op_div(op) ? a_mag : b_mag};
        state_d    = dz_d ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_div(op_q)) begin
          rem_d = WIDTH'(ge ? shifted - {1'b0, mb_q} : shifted);
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
        end else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (dz_q) div_zero_d = 1'b1;
        else if (op_div(op_q)) {hi_d, lo_d} = {rem_fix, quo_fix};
        else {hi_d, lo_d} = prod_fix;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      sres_q     <= 1'b0;
      srem_q     <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      sres_q     <= sres_d;
      srem_q     <= srem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of 32- and 8-bit muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, start_r = 1'b0, sel8 = 1'b0;
  logic [1:0]  op_r = '0;
  logic [31:0] a_r = '0, b_r = '0;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        busy_s, done_s, dz_s;
  logic [31:0] hi_s, lo_s;
  int          n_chk = 0, n_fail = 0;
  longint unsigned exp_hi[2], exp_lo[2];

  muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .start(start_r & ~sel8), .op(op_r),
    .a(a_r), .b(b_r), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32));
  muldiv_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .start(start_r & sel8), .op(op_r),
    .a(a_r[7:0]), .b(b_r[7:0]), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign dz_s   = sel8 ? dz8 : dz32;
  assign hi_s   = sel8 ? {24'd0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'd0, lo8} : lo32;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [1:0] o, input longint unsigned x, y,
                                output longint unsigned h, l, output bit dz);
    longint unsigned m = (64'd1 << w) - 1;
    longint sx, sy, p;
    x &= m;
    y &= m;
    sx = !o[0] ? (longint'(x << (64 - w)) >>> (64 - w)) : longint'(x);
    sy = !o[0] ? (longint'(y << (64 - w)) >>> (64 - w)) : longint'(y);
    dz = o[1] && (y == 0);
    h = 0;
    l = 0;
    if (!o[1]) begin
      p = sx * sy;
      h = ($unsigned(p) >> w) & m;
      l = $unsigned(p) & m;
    end else if (!dz) begin
      h = $unsigned(sx % sy) & m;
      l = $unsigned(sx / sy) & m;
    end
  endfunction

  task automatic run(input logic [1:0] o, input logic [31:0] x, y, input int glitch);
    int w = sel8 ? 8 : 32;
    int n = 0, nb = 0;
    longint unsigned h, l;
    bit dz;
    model(w, o, x, y, h, l, dz);
    if (dz) begin
      h = exp_hi[sel8];
      l = exp_lo[sel8];
    end
    exp_hi[sel8] = h;
    exp_lo[sel8] = l;
    @(negedge clk);
    start_r = 1'b1; op_r = o; a_r = x; b_r = y;
    @(posedge clk);
    #1;
    start_r = 1'b0; a_r = $urandom; b_r = $urandom; op_r = 2'($urandom);
    check("done_low_after_accept", done_s, 0);
    nb += int'(busy_s);
    while (!done_s && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      start_r = (n == glitch);
      if (n == glitch) begin a_r = $urandom; b_r = $urandom; op_r = 2'($urandom); end
      if (!done_s) nb += int'(busy_s);
    end
    start_r = 1'b0;
    check("latency", n, dz ? 1 : w + 1);
    check("busy_cycles", nb, dz ? 1 : w + 1);
    check("busy_in_done", busy_s, 0);
    check("hi", hi_s, h);
    check("lo", lo_s, l);
    check("div_zero", dz_s, dz);
  endtask

  task automatic run_rand(input int cnt);
    logic [31:0] v[2];
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0: v[k] = 0;
          1: v[k] = sel8 ? 32'h80 : 32'h8000_0000;
          2: v[k] = sel8 ? 32'hFF : 32'hFFFF_FFFF;
          default: v[k] = $urandom;
        endcase
      end
      run(2'($urandom_range(0, 3)), v[0], v[1], 0);
    end
  endtask

  initial begin
    int seen;
    exp_hi = '{0, 0};
    exp_lo = '{0, 0};
    #1;
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_hi", hi32, 0);
    check("rst_lo", lo32, 0);
    check("rst_dz", dz32, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0);
    check("tp_mult_hi", hi32, 32'hFFFF_FFFF);
    check("tp_mult_lo", lo32, 32'hFFFF_FFEB);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("tp_multu_hi", hi32, 32'hFFFF_FFFE);
    check("tp_multu_lo", lo32, 32'h0000_0001);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("tp_div_lo", lo32, 32'hFFFF_FFFD);
    check("tp_div_hi", hi32, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'd68, 32'd7, 0);
    run(OP_DIVU, 32'd100, 32'd0, 0);
    check("tp_dz_hi", hi32, 32'd5);
    check("tp_dz_lo", lo32, 32'd9);
    check("tp_dz_flag", dz32, 1);
    run(OP_DIVU, 32'd100, 32'd7, 0);
    check("tp_divu_lo", lo32, 32'd14);
    check("tp_divu_hi", hi32, 32'd2);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("tp_ovf_lo", lo32, 32'h8000_0000);
    check("tp_ovf_hi", hi32, 32'h0);
    run(OP_MULT, 32'd12345, 32'hFFFF_FF9D, 10);
    run_rand(30);
    @(negedge clk);
    start_r = 1'b1; op_r = OP_DIV; a_r = 32'd1000; b_r = 32'd3;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy32, 0);
    check("abort_done", done32, 0);
    check("abort_hi", hi32, 0);
    check("abort_lo", lo32, 0);
    check("abort_dz", dz32, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= int'(done32);
    end
    check("abort_no_done", seen, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '{0, 0};
    exp_lo = '{0, 0};
    run(OP_DIV, 32'd5, 32'd0, 0);
    sel8 = 1'b1;
    run(OP_MULT, 32'h80, 32'h80, 0);
    check("tp8_mult_hi", hi8, 8'h40);
    check("tp8_mult_lo", lo8, 8'h00);
    run(OP_DIVU, 32'hFF, 32'h10, 0);
    check("tp8_divu_lo", lo8, 8'h0F);
    check("tp8_divu_hi", hi8, 8'h0F);
    run_rand(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
